// File: rtl/circle_plot_if.sv
// Handshake bundle between the circle plotter, the circle calculator and the pixel writer.
// The slave modport is the plotter's view; the master modport is the surrounding logic's view.
interface circle_plot_if #(
  parameter int CORDW = 16
);
  logic                    start;
  logic signed [CORDW-1:0] cx;
  logic signed [CORDW-1:0] cy;
  logic                    circ_start;
  logic                    circ_valid;
  logic signed [CORDW-1:0] circ_xa;
  logic signed [CORDW-1:0] circ_ya;
  logic                    circ_done;
  logic                    circ_oe;
  logic                    oe;
  logic signed [CORDW-1:0] x;
  logic signed [CORDW-1:0] y;
  logic                    busy;
  logic                    valid;
  logic                    done;

  modport slave (
    input  start, cx, cy, circ_valid, circ_xa, circ_ya, circ_done, oe,
    output circ_start, circ_oe, x, y, busy, valid, done
  );

  modport master (
    output start, cx, cy, circ_valid, circ_xa, circ_ya, circ_done, oe,
    input  circ_start, circ_oe, x, y, busy, valid, done
  );
endinterface

// File: rtl/circle_plot.sv
// Expands each (xa, ya) distance pair from the circle calculator into four
// quadrant-symmetric pixels about (cx, cy) and streams them to the pixel writer.
module circle_plot #(
  parameter int CORDW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  circle_plot_if.slave  bus
);

  // state  | meaning
  // IDLE   | waiting for start
  // LAUNCH | one-cycle start pulse to the calculator
  // FETCH  | accepting the next distance pair, or finishing
  // PLOT   | presenting the four quadrant pixels of one pair
  typedef enum logic [1:0] {IDLE, LAUNCH, FETCH, PLOT} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [1:0]              r_q;
  logic signed [CORDW-1:0] r_cx;
  logic signed [CORDW-1:0] r_cy;
  logic signed [CORDW-1:0] r_xa;
  logic signed [CORDW-1:0] r_ya;
  logic signed [CORDW-1:0] r_x;
  logic signed [CORDW-1:0] r_y;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_done_pend;

  logic [1:0]              w_sel_q;
  logic signed [CORDW-1:0] w_sxa;
  logic signed [CORDW-1:0] w_sya;
  logic signed [CORDW-1:0] w_px;
  logic signed [CORDW-1:0] w_py;

  // In FETCH the first pixel is built straight from the incoming pair.
  always_comb begin
    w_sel_q = r_q + 2'd1;
    w_sxa   = r_xa;
    w_sya   = r_ya;
    if (r_state == FETCH) begin
      w_sel_q = 2'd0;
      w_sxa   = bus.circ_xa;
      w_sya   = bus.circ_ya;
    end
    case (w_sel_q)
      2'd0: begin w_px = r_cx - w_sxa; w_py = r_cy + w_sya; end
      2'd1: begin w_px = r_cx - w_sya; w_py = r_cy - w_sxa; end
      2'd2: begin w_px = r_cx + w_sxa; w_py = r_cy - w_sya; end
      default: begin w_px = r_cx + w_sya; w_py = r_cy + w_sxa; end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = LAUNCH;
      LAUNCH:  w_next = FETCH;
      FETCH: begin
        if (bus.circ_valid)                   w_next = PLOT;
        else if (r_done_pend || bus.circ_done) w_next = IDLE;
      end
      PLOT:    if (bus.oe && r_q == 2'd3) w_next = FETCH;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_q         <= 2'd0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_xa        <= '0;
      r_ya        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_done_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      // The calculator's done pulse usually lands while still plotting the last pair.
      if (r_busy && bus.circ_done) r_done_pend <= 1'b1;
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_cx        <= bus.cx;
            r_cy        <= bus.cy;
            r_busy      <= 1'b1;
            r_done_pend <= 1'b0;
          end
        end
        FETCH: begin
          if (bus.circ_valid) begin
            r_xa <= bus.circ_xa;
            r_ya <= bus.circ_ya;
            r_q  <= 2'd0;
            r_x  <= w_px;
            r_y  <= w_py;
          end else if (r_done_pend || bus.circ_done) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
        PLOT: begin
          if (bus.oe && r_q != 2'd3) begin
            r_q <= r_q + 2'd1;
            r_x <= w_px;
            r_y <= w_py;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.circ_start = (r_state == LAUNCH);
  assign bus.circ_oe    = (r_state == FETCH);
  assign bus.valid      = (r_state == PLOT);
  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_circle_plot.sv
// Directed and randomized checks of circle_plot against a quadrant-expansion model,
// with a behavioural circle calculator and pixel writer around the DUT.
module tb_circle_plot;

  logic clk;
  logic rst_n;

  circle_plot_if #(.CORDW(16)) bus16 ();
  circle_plot_if #(.CORDW(8))  bus8  ();

  circle_plot #(.CORDW(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  circle_plot #(.CORDW(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int checks = 0;
  int errors = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int calc_xa[$];
  int calc_ya[$];
  int done_dly = 1;
  int gap_max = 0;
  bit calc_abort = 0;
  bit calc_running = 0;
  int oe_mode = 0;
  bit oe_manual = 1;

  int cs_cnt, done_cnt, done_busy_err, oe_err;
  bit done_in_plot;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Pixel for quadrant q of pair (xa, ya) about (cx, cy), wrapped to 16 bits.
  function automatic logic [31:0] exp_pix(input int cx, input int cy, input int xa,
                                          input int ya, input int q);
    int px, py;
    case (q)
      0: begin px = cx - xa; py = cy + ya; end
      1: begin px = cx - ya; py = cy - xa; end
      2: begin px = cx + xa; py = cy - ya; end
      default: begin px = cx + ya; py = cy + xa; end
    endcase
    return {px[15:0], py[15:0]};
  endfunction

  // Pixel writer ready signal.
  initial begin
    bus16.oe = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (oe_mode)
        0: bus16.oe = 1'b1;
        1: bus16.oe = 1'($urandom_range(0, 1));
        default: bus16.oe = oe_manual;
      endcase
    end
  end

  // Observer on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bus16.valid && bus16.oe) got_q.push_back({bus16.x, bus16.y});
      if (bus16.circ_start) cs_cnt++;
      if (bus16.done) begin
        done_cnt++;
        if (bus16.busy) done_busy_err++;
      end
      if (bus16.circ_oe && (bus16.valid || !bus16.busy)) oe_err++;
      if (bus16.circ_done && bus16.valid) done_in_plot = 1'b1;
    end
  end

  // Behavioural circle calculator: hands out the queued pairs, then pulses done.
  initial begin
    int tmo, g;
    bus16.circ_valid = 1'b0;
    bus16.circ_done  = 1'b0;
    bus16.circ_xa    = '0;
    bus16.circ_ya    = '0;
    forever begin
      @(posedge clk); #1;
      if (bus16.circ_start && !calc_abort) begin
        calc_running = 1'b1;
        foreach (calc_xa[i]) begin
          if (!calc_abort) begin
            bus16.circ_valid = 1'b1;
            bus16.circ_xa    = 16'(calc_xa[i]);
            bus16.circ_ya    = 16'(calc_ya[i]);
            tmo = 0;
            while (!bus16.circ_oe && !calc_abort && tmo < 300) begin
              @(posedge clk); #1;
              tmo++;
            end
            @(posedge clk); #1;
            bus16.circ_valid = 1'b0;
            g = (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
            repeat (g) begin @(posedge clk); #1; end
          end
        end
        if (!calc_abort) begin
          repeat (done_dly) begin @(posedge clk); #1; end
          bus16.circ_done = 1'b1;
          @(posedge clk); #1;
          bus16.circ_done = 1'b0;
        end
        calc_running = 1'b0;
      end
    end
  end

  task automatic begin_draw(input int cx, input int cy, input int dly, input int gmax,
                            input bit bogus);
    got_q.delete();
    exp_q.delete();
    cs_cnt = 0; done_cnt = 0; done_busy_err = 0; oe_err = 0; done_in_plot = 1'b0;
    done_dly = dly;
    gap_max  = gmax;
    foreach (calc_xa[i])
      for (int q = 0; q < 4; q++) exp_q.push_back(exp_pix(cx, cy, calc_xa[i], calc_ya[i], q));
    bus16.cx = 16'(cx);
    bus16.cy = 16'(cy);
    bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    bus16.cx = 16'($urandom);
    bus16.cy = 16'($urandom);
    if (bogus) begin
      repeat (3) begin @(posedge clk); #1; end
      bus16.cx = 16'(cx + 7);
      bus16.start = 1'b1;
      @(posedge clk); #1;
      bus16.start = 1'b0;
    end
  endtask

  task automatic finish_draw(input string tag);
    int tmo = 0;
    while (done_cnt == 0 && tmo < 3000) begin
      @(posedge clk); #1;
      tmo++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
    repeat (4) begin @(posedge clk); #1; end
    chk({tag, "_pix_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_pix%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_circ_start_cnt"}, cs_cnt, 1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_with_busy"}, done_busy_err, 0);
    chk({tag, "_circ_oe_outside_fetch"}, oe_err, 0);
    chk({tag, "_busy_end"}, {31'd0, bus16.busy}, 0);
  endtask

  initial begin
    int tmo, n, rcx, rcy, k;
    rst_n = 1'b0;
    bus16.start = 1'b0; bus16.cx = '0; bus16.cy = '0;
    bus8.start = 1'b0; bus8.cx = '0; bus8.cy = '0; bus8.oe = 1'b1;
    bus8.circ_valid = 1'b0; bus8.circ_xa = '0; bus8.circ_ya = '0; bus8.circ_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst16_ctrl", {27'd0, bus16.busy, bus16.valid, bus16.done, bus16.circ_start, bus16.circ_oe}, 0);
    chk("rst16_xy", {bus16.x, bus16.y}, 0);
    chk("rst8_ctrl", {27'd0, bus8.busy, bus8.valid, bus8.done, bus8.circ_start, bus8.circ_oe}, 0);
    chk("rst8_xy", {16'd0, bus8.x, bus8.y}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8-bit wrap: cx=120, xa=-10 gives x = 130 mod 256 = -126.
    bus8.cx = 8'sd120; bus8.cy = 8'sd0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    tmo = 0;
    while (!bus8.circ_oe && tmo < 20) begin @(posedge clk); #1; tmo++; end
    chk("w8_fetch", {31'd0, bus8.circ_oe}, 1);
    bus8.circ_valid = 1'b1; bus8.circ_xa = -8'sd10; bus8.circ_ya = 8'sd0;
    @(posedge clk); #1;
    bus8.circ_valid = 1'b0;
    chk("w8_valid", {31'd0, bus8.valid}, 1);
    chk("w8_first_pix", {16'd0, bus8.x, bus8.y}, {16'd0, 8'h82, 8'h00});
    tmo = 0;
    while (!bus8.circ_oe && tmo < 20) begin @(posedge clk); #1; tmo++; end
    bus8.circ_done = 1'b1;
    @(posedge clk); #1;
    bus8.circ_done = 1'b0;
    chk("w8_done", {30'd0, bus8.done, bus8.busy}, 32'd2);

    // r0=0 about (10,10)
    calc_xa = '{0}; calc_ya = '{0};
    begin_draw(10, 10, 1, 0, 1'b0);
    finish_draw("r0");
    chk("r0_first", got_q[0], {16'd10, 16'd10});

    // r0=3 about (20,20), with a start pulse while busy
    calc_xa = '{-3, -3, -2}; calc_ya = '{0, 1, 2};
    begin_draw(20, 20, 1, 0, 1'b1);
    finish_draw("r3");
    chk("r3_first", got_q[0], {16'd23, 16'd20});
    chk("r3_fourth", got_q[3], {16'd20, 16'd17});

    // r0=1 about (5,5): done arrives during PLOT
    calc_xa = '{-1, 0}; calc_ya = '{0, 1};
    begin_draw(5, 5, 1, 0, 1'b0);
    finish_draw("r1pend");
    chk("r1pend_done_in_plot", {31'd0, done_in_plot}, 1);
    chk("r1pend_pix4", got_q[4], {16'd5, 16'd6});

    // same circle, done arrives while waiting in FETCH
    begin_draw(5, 5, 10, 0, 1'b0);
    finish_draw("r1late");
    chk("r1late_done_in_plot", {31'd0, done_in_plot}, 0);

    // stall the second pixel for 5 cycles
    oe_mode = 2; oe_manual = 1'b1;
    @(posedge clk); #1;
    calc_xa = '{-3, -3, -2}; calc_ya = '{0, 1, 2};
    begin_draw(20, 20, 1, 0, 1'b0);
    tmo = 0;
    while (got_q.size() < 1 && tmo < 50) begin @(posedge clk); #1; tmo++; end
    chk("stall_xy0", {bus16.x, bus16.y}, {16'd20, 16'd23});
    oe_manual = 1'b0;
    for (k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_v%0d", k), {31'd0, bus16.valid}, 1);
      chk($sformatf("stall_xy%0d", k), {bus16.x, bus16.y}, {16'd20, 16'd23});
    end
    oe_manual = 1'b1;
    finish_draw("stall");
    oe_mode = 0;

    // randomized draws
    for (int t = 0; t < 6; t++) begin
      calc_xa.delete(); calc_ya.delete();
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < n; i++) begin
        calc_xa.push_back(-int'($urandom_range(0, 300)));
        calc_ya.push_back(int'($urandom_range(0, 300)));
      end
      rcx = int'($urandom_range(0, 65535));
      rcy = int'($urandom_range(0, 65535));
      oe_mode = (t % 2 == 0) ? 1 : 0;
      begin_draw(rcx, rcy, int'($urandom_range(0, 8)), 2, 1'($urandom_range(0, 1)));
      finish_draw($sformatf("rnd%0d", t));
    end
    oe_mode = 0;

    // reset while showing quadrant 2
    calc_xa = '{-3, -3, -2}; calc_ya = '{0, 1, 2};
    begin_draw(20, 20, 1, 0, 1'b0);
    tmo = 0;
    while (got_q.size() < 2 && tmo < 50) begin @(posedge clk); #1; tmo++; end
    chk("mid_q2_pix", {bus16.x, bus16.y}, {16'd17, 16'd20});
    rst_n = 1'b0;
    calc_abort = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ctrl", {29'd0, bus16.valid, bus16.busy, bus16.done}, 0);
    rst_n = 1'b1;
    tmo = 0;
    while (calc_running && tmo < 400) begin @(posedge clk); #1; tmo++; end
    calc_abort = 1'b0;
    bus16.circ_valid = 1'b0;
    bus16.circ_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_rst_idle", {30'd0, bus16.busy, bus16.circ_oe}, 0);

    // recovery draw after reset
    calc_xa = '{-2, -1}; calc_ya = '{0, 2};
    begin_draw(-100, 300, 2, 1, 1'b0);
    finish_draw("recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/circle_plot.md
Name: circle_plot

Overview:
- Consumer end of the circle distance interface: drives the circle calculator's start, accepts each (xa, ya) distance pair through its valid/oe handshake and expands it into four quadrant-symmetric pixel coordinates about a centre (cx, cy).
- Presents pixels one at a time to a downstream pixel writer with its own valid/oe handshake.
- Sits between the circle calculator and the framebuffer write path in the graphics pipeline.

Parameters:
- CORDW, 16, signed coordinate width for centre, distances and output pixels.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- start  in  1  begin drawing; cx/cy sampled on this cycle
- cx  in  CORDW signed  circle centre x
- cy  in  CORDW signed  circle centre y
- circ_start  out  1  one-cycle start pulse to the circle calculator
- circ_valid  in  1  calculator distance pair valid
- circ_xa  in  CORDW signed  x distance (≤0)
- circ_ya  in  CORDW signed  y distance (≥0)
- circ_done  in  1  calculator finished (one-cycle pulse)
- circ_oe  out  1  accept current pair (the calculator's output enable)
- oe  in  1  downstream accepts current pixel
- x  out  CORDW signed  pixel x
- y  out  CORDW signed  pixel y
- busy  out  1  drawing in progress
- valid  out  1  x/y valid
- done  out  1  drawing complete, high for one cycle

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE. busy=0, valid=0, done=0, circ_start=0, circ_oe=0, x=0, y=0, done_pend=0. Reset has priority over all other events, including mid-draw; the calculator is reset separately by the system.
- States: IDLE, LAUNCH, FETCH, PLOT, with a 2-bit quadrant counter q.
- IDLE:
  - done=0.
  - On start: latch cx/cy, busy=1, clear done_pend, go to LAUNCH.
  - start is ignored whenever busy=1.
- LAUNCH:
  - circ_start=1 for exactly this cycle.
  - Go to FETCH.
- FETCH:
  - circ_oe=1, combinational, equal to (state==FETCH).
  - If circ_valid: latch xa/ya, q=0, go to PLOT.
  - Else if done_pend or circ_done: busy=0, done=1 for one cycle, go to IDLE.
  - circ_valid has priority over done.
- done_pend:
  - Set whenever circ_done=1 while busy; cleared on start.
  - Required because the done pulse arrives about 3 cycles after the pair handshake, while the block is still in PLOT.
- PLOT:
  - valid=1, combinational, equal to (state==PLOT).
  - x/y are registered from the latched values:
    - q=0: (cx−xa, cy+ya)
    - q=1: (cx−ya, cy−xa)
    - q=2: (cx+xa, cy−ya)
    - q=3: (cx+ya, cy+xa)
  - The first pixel is on x/y in the cycle after the FETCH capture.
  - While oe=0: hold x/y/valid stable.
  - On oe=1 with q<3: q+1, next pixel presented the following cycle. With oe held high, a new pixel appears every cycle.
  - On oe=1 with q=3: go to FETCH next cycle.
- Arithmetic: CORDW-bit two's-complement add/sub, wrapping modulo 2^CORDW. No saturation and no clipping.
- Duplicate pixels (r=0, or axis/diagonal points) are emitted as-is; there is no deduplication.
- Every distance pair yields exactly 4 pixels. done follows the last pixel's oe by at least 1 cycle.

Test Plan:
- r0=0, cx=cy=10, oe=1: four pixels (10,10) ×4, then done for one cycle, busy falls on the same edge, circ_start seen exactly once.
- r0=3, cx=cy=20, oe=1: first four pixels (23,20), (20,23), (17,20), (20,17) on consecutive cycles; circ_oe high only in FETCH.
- r0=1, cx=cy=5: eight pixels (6,5), (5,6), (4,5), (5,4), (5,6), (4,5), (5,4), (6,5); done is asserted although circ_done pulsed while in PLOT (done_pend path).
- Stall: r0=3, oe low for 5 cycles on the second pixel: (20,23) is held stable with valid=1 for all 5 cycles; no pixel is lost or repeated.
- CORDW=8, cx=120, cy=0, r0=10: first pixel x wraps to −126, y=0.
- Reset mid-draw: rst_n low during PLOT q=2 → next cycle valid=0, busy=0, done=0. A start pulse while busy is ignored: cx/cy are unchanged and there is no extra circ_start.
